// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit byte-path arbiter.
package usb_tx_pkg;

    typedef enum logic [1:0] {IDLE, SEND_PID, SEND_PAYLOAD, GAP} arb_state_t;
    typedef enum logic {SRC_HS, SRC_DP} src_t;

    localparam logic [7:0] ACK   = 8'hD2;
    localparam logic [7:0] NAK   = 8'h5A;
    localparam logic [7:0] DATA0 = 8'hC3;
    localparam logic [7:0] DATA1 = 8'h4B;

    localparam int DEF_MAX_LEN     = 64;
    localparam int DEF_GAP_CYCLES  = 16;
    localparam int DEF_STALL_LIMIT = 255;

endpackage

// File: rtl/usb_tx_stall_wdog.sv
// Counts consecutive starved payload clocks and pulses abort on the STALL_LIMIT-th one.
// Only instantiated when TX_ARB_WATCHDOG_EN is defined.
module usb_tx_stall_wdog
    import usb_tx_pkg::*;
#(
    parameter int STALL_LIMIT = DEF_STALL_LIMIT
)(
    input  logic clk,
    input  logic n_rst,
    input  logic active,
    input  logic dp_valid,
    output logic abort
);

    localparam int CNT_W = $clog2(STALL_LIMIT + 1);

    logic [CNT_W-1:0] stall_cnt_reg;

    // The register holds stalls seen before this clock, so this clock is the last one allowed.
    assign abort = active && !dp_valid && (stall_cnt_reg == CNT_W'(STALL_LIMIT - 1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt_reg <= '0;
        end else if (!active || dp_valid || abort) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Arbitrates the shared USB transmit byte path between the handshake and data sources.
// Define TX_ARB_WATCHDOG_EN to abort a payload starved for STALL_LIMIT clocks.
module usb_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int MAX_LEN     = DEF_MAX_LEN,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int STALL_LIMIT = DEF_STALL_LIMIT,
    parameter int LEN_W       = $clog2(MAX_LEN + 1)
)(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             hs_req,
    input  logic [7:0]       hs_pid,
    input  logic             dp_req,
    input  logic [7:0]       dp_pid,
    input  logic [LEN_W-1:0] dp_len,
    input  logic [7:0]       dp_byte,
    input  logic             dp_valid,
    output logic             dp_pop,
    output logic             hs_grant,
    output logic             dp_grant,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic             tx_abort,
    output logic             busy
);

    localparam int               GAP_W     = $clog2(GAP_CYCLES + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    arb_state_t       state_reg, state_next;
    src_t             src_reg, src_next;
    src_t             last_winner_reg, last_winner_next;
    logic [7:0]       pid_reg, pid_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] remain_reg, remain_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;

    logic             hs_win;
    logic             dp_win;
    logic             xfer;
    logic             wdog_abort;
    logic [LEN_W-1:0] dp_len_clamped;

    // On a tie the source that did not win last time goes next.
    assign hs_win         = hs_req && (!dp_req || last_winner_reg == SRC_DP);
    assign dp_win         = dp_req && !hs_win;
    assign dp_len_clamped = (dp_len > MAX_LEN_V) ? MAX_LEN_V : dp_len;
    assign xfer           = tx_valid && tx_ready;

`ifdef TX_ARB_WATCHDOG_EN
    usb_tx_stall_wdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall_wdog (
        .clk      (clk),
        .n_rst    (n_rst),
        .active   (state_reg == SEND_PAYLOAD),
        .dp_valid (dp_valid),
        .abort    (wdog_abort)
    );
`else
    // Constant-false, but keeps STALL_LIMIT referenced when the watchdog is absent.
    assign wdog_abort = (STALL_LIMIT < 0);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg       <= IDLE;
            src_reg         <= SRC_HS;
            last_winner_reg <= SRC_DP;
            pid_reg         <= '0;
            len_reg         <= '0;
            remain_reg      <= '0;
            gap_cnt_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            src_reg         <= src_next;
            last_winner_reg <= last_winner_next;
            pid_reg         <= pid_next;
            len_reg         <= len_next;
            remain_reg      <= remain_next;
            gap_cnt_reg     <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        src_next         = src_reg;
        last_winner_next = last_winner_reg;
        pid_next         = pid_reg;
        len_next         = len_reg;
        remain_next      = remain_reg;
        gap_cnt_next     = gap_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (hs_win) begin
                    state_next       = SEND_PID;
                    src_next         = SRC_HS;
                    last_winner_next = SRC_HS;
                    pid_next         = hs_pid;
                    len_next         = '0;
                end else if (dp_win) begin
                    state_next       = SEND_PID;
                    src_next         = SRC_DP;
                    last_winner_next = SRC_DP;
                    pid_next         = dp_pid;
                    len_next         = dp_len_clamped;
                end
            end
            SEND_PID: begin
                if (xfer) begin
                    if (src_reg == SRC_HS || len_reg == '0) begin
                        state_next   = GAP;
                        gap_cnt_next = '0;
                    end else begin
                        state_next  = SEND_PAYLOAD;
                        remain_next = len_reg;
                    end
                end
            end
            SEND_PAYLOAD: begin
                if (wdog_abort) begin
                    state_next   = GAP;
                    gap_cnt_next = '0;
                end else if (xfer) begin
                    remain_next = remain_reg - LEN_W'(1);
                    if (remain_reg == LEN_W'(1)) begin
                        state_next   = GAP;
                        gap_cnt_next = '0;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
                    state_next   = IDLE;
                    gap_cnt_next = '0;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dp_pop   = 1'b0;
        hs_grant = 1'b0;
        dp_grant = 1'b0;
        tx_byte  = 8'h00;
        tx_valid = 1'b0;
        tx_sop   = 1'b0;
        tx_eop   = 1'b0;
        tx_abort = 1'b0;
        busy     = (state_reg != IDLE);
        case (state_reg)
            SEND_PID: begin
                hs_grant = (src_reg == SRC_HS);
                dp_grant = (src_reg == SRC_DP);
                tx_byte  = pid_reg;
                tx_valid = 1'b1;
                tx_sop   = 1'b1;
                tx_eop   = (src_reg == SRC_HS) || (len_reg == '0);
            end
            SEND_PAYLOAD: begin
                dp_grant = 1'b1;
                tx_byte  = dp_byte;
                tx_valid = dp_valid && !wdog_abort;
                tx_eop   = (remain_reg == LEN_W'(1));
                dp_pop   = dp_valid && !wdog_abort && tx_ready;
                tx_abort = wdog_abort;
            end
            default: ;
        endcase
    end

endmodule
